// File: rtl/riscv_pkg.sv
// Shared pipeline-control types: register addresses, forwarding selects, control FSM states.
package riscv_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // EX operand source select
    typedef enum logic [1:0] {
        REGFILE = 2'b00,
        EX_MEM  = 2'b01,
        MEM_WB  = 2'b10
    } fwd_sel_e;

    // Pipeline control FSM states
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MD_BUSY  = 2'b01,
        MEM_WAIT = 2'b10
    } pipe_ctrl_state_e;

    // Pick the youngest in-flight producer of src; x0 is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input reg_addr_t src,
        input reg_addr_t exmem_rd,
        input logic      exmem_we,
        input reg_addr_t memwb_rd,
        input logic      memwb_we
    );
        fwd_sel_e sel;
        sel = REGFILE;
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == src)) begin
            sel = EX_MEM;
        end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == src)) begin
            sel = MEM_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational EX-stage operand forwarding for both source operands.
module forward_unit
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_ex_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_ex_rs2_addr,
    input  logic [REG_ADDR_W-1:0] i_exmem_rd_addr,
    input  logic                  i_exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_memwb_rd_addr,
    input  logic                  i_memwb_reg_write,
    output fwd_sel_e              o_fwd_a,
    output fwd_sel_e              o_fwd_b
);

    // Same priority rule applied independently to each operand
    always_comb begin
        o_fwd_a = fwd_select(i_ex_rs1_addr, i_exmem_rd_addr, i_exmem_reg_write,
                             i_memwb_rd_addr, i_memwb_reg_write);
        o_fwd_b = fwd_select(i_ex_rs2_addr, i_exmem_rd_addr, i_exmem_reg_write,
                             i_memwb_rd_addr, i_memwb_reg_write);
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Five-stage pipeline hazard/control unit: load-use interlock, branch flush,
// multi-cycle mul/div and data-memory wait freezes, forwarding, perf counters.
module pipe_ctrl_unit
    import riscv_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 34,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] idex_rd_addr,
    input  logic                  idex_mem_read,
    input  logic                  idex_valid,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic                  exmem_reg_write,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
    input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
    input  logic                  ex_branch_taken,
    input  logic                  ex_md_req,
    input  logic                  dmem_wait,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_stall,
    output logic                  exmem_stall,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output fwd_sel_e              fwd_a,
    output fwd_sel_e              fwd_b,
    output logic                  md_done,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int unsigned MD_CNT_W = $clog2(MD_LATENCY);
    localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY - 1);

    pipe_ctrl_state_e    r_state;
    pipe_ctrl_state_e    w_state_nxt;
    logic [MD_CNT_W-1:0] r_md_cnt;
    logic [MD_CNT_W-1:0] w_md_cnt_nxt;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [CNT_W-1:0]    r_flush_events;

    logic w_hazard;
    logic w_freeze;
    logic w_load_use;
    logic w_br_flush;
    logic w_md_done;

    // Load in ID/EX whose destination is read by the instruction in ID
    assign w_hazard = idex_valid && idex_mem_read && (idex_rd_addr != '0) &&
                      (((idex_rd_addr == id_rs1_addr) && id_use_rs1) ||
                       ((idex_rd_addr == id_rs2_addr) && id_use_rs2));

    // FSM state and mul/div down-counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // Next state and control decode; EX is frozen outside RUN so hazards are ignored there
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        w_freeze     = 1'b0;
        w_load_use   = 1'b0;
        w_br_flush   = 1'b0;
        w_md_done    = 1'b0;
        case (r_state)
            RUN: begin
                w_br_flush = ex_branch_taken;
                w_load_use = w_hazard && !ex_branch_taken;
                if (dmem_wait) begin
                    w_state_nxt = MEM_WAIT;
                end else if (ex_md_req) begin
                    w_state_nxt  = MD_BUSY;
                    w_md_cnt_nxt = MD_LOAD;
                end
            end
            MD_BUSY: begin
                if (r_md_cnt == '0) begin
                    w_md_done   = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_freeze     = 1'b1;
                    w_md_cnt_nxt = r_md_cnt - MD_CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_wait) begin
                    w_freeze = 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    // Stall/flush outputs; all forced low while reset is held
    assign pc_stall    = !reset && (w_freeze || w_load_use);
    assign ifid_stall  = !reset && (w_freeze || w_load_use);
    assign idex_stall  = !reset && w_freeze;
    assign exmem_stall = !reset && w_freeze;
    assign ifid_flush  = !reset && w_br_flush;
    assign idex_flush  = !reset && (w_br_flush || w_load_use);
    assign exmem_flush = 1'b0;
    assign memwb_flush = !reset && w_freeze;
    assign md_done     = !reset && w_md_done;

    // Performance counters, free-running and wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (pc_stall) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (w_br_flush) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

    forward_unit u_forward_unit (
        .i_ex_rs1_addr     (ex_rs1_addr),
        .i_ex_rs2_addr     (ex_rs2_addr),
        .i_exmem_rd_addr   (exmem_rd_addr),
        .i_exmem_reg_write (exmem_reg_write),
        .i_memwb_rd_addr   (memwb_rd_addr),
        .i_memwb_reg_write (memwb_reg_write),
        .o_fwd_a           (fwd_a),
        .o_fwd_b           (fwd_b)
    );

endmodule
